door_motor_arbiter: RTL
=======================

# door_motor_arbiter

Shares one garage motor supply between two door controllers so only one door moves at a time. Each door FSM's up/down requests pass through this block. It grants the supply round-robin, gates motor drive with the limit and safety sensors, and inserts a settle gap between grants. A travel watchdog faults any door whose motor runs too long. It sits between the per-door opener FSMs and the motor drivers.

## Interface
- TIMEOUT, 200: maximum driven cycles per grant before the door is faulted (≥2).
- SETTLE, 4: dead cycles between the end of one grant and the next grant (≥1).
- clk  in  1  system clock, rising edge.
- r  in  1  reset, asynchronous, active-high.
- req_u  in  2  up request per door (bit i = door i).
- req_d  in  2  down request per door.
- c  in  2  closed limit sensor per door.
- o  in  2  open limit sensor per door.
- s  in  2  safety (obstruction) sensor per door.
- clr  in  1  synchronous fault clear.
- u  out  2  up motor drive per door.
- d  out  2  down motor drive per door.
- gnt  out  2  registered grant, one-hot or zero.
- fault  out  2  sticky watchdog fault per door.
- State  out  2  arbiter state: Idle=0, Run=1, Settle=2; encoding 3 is unused and returns to Idle at the next edge.

## Operation
- Valid request: vreq[i] = (req_u[i] XOR req_d[i]) AND NOT fault[i]. If req_u and req_d are both 1, that door has no request.
- Idle:
  - If any vreq is set, grant one door and go to Run.
  - If both are set, the door that is not `last` wins.
  - `last` is updated to the granted door.
  - With no request, stay in Idle.
- Run:
  - u[i] = gnt[i] & req_u[i] & !o[i].
  - d[i] = gnt[i] & req_d[i] & !c[i] & !s[i].
  - u and d are combinational from the registered gnt and the live sensor inputs, so a limit or safety input cuts drive in the same cycle.
  - The drive counter increments only on edges where the granted door's u or d is 1. Stalled cycles (limit, safety) do not count.
  - When vreq of the granted door is 0 at an edge: gnt is cleared, the counter clears, and State goes to Settle.
  - When the drive counter is at TIMEOUT-1 and drive is asserted at an edge: set fault[granted], clear gnt, go to Settle.
- Settle:
  - gnt=00; u and d are 00.
  - The settle counter runs for SETTLE cycles, then State returns to Idle.
  - Requests arriving during Settle are held off, not lost.
- Faults:
  - A faulted door's requests are ignored. The other door is still served.
  - clr=1 at an edge clears all fault bits.
  - If a timeout and clr occur at the same edge, the timeout wins and the fault bit is set.
- Counter widths are $clog2(TIMEOUT+1) and $clog2(SETTLE+1). Counters never wrap: both clear on every state change.

## Timing
- Reset values: State=0, gnt=00, fault=00, u=00, d=00, counters 0, last=1 (door 0 has first priority).
- Reset applied mid-Run drops u and d immediately, without waiting for a clock edge.
- Grant latency: if vreq is sampled at edge k in Idle, gnt and State=Run are visible after edge k, and drive is asserted in the same cycle.
- Release: vreq low at edge k in Run gives Settle after edge k. Idle is reached after edge k+SETTLE. The earliest next grant is at edge k+SETTLE+1.
- Watchdog: a single grant drives the motor for at most TIMEOUT cycles.
- Sensors are combinational gates only. Sensor edges alone never change state.

## Test plan
Bench runs with TIMEOUT=8, SETTLE=2.
- Reset: r=1, req_u=01 gives gnt=00, u=00, State=0, fault=00. After r=0, the first edge gives gnt=01, u=01, State=1.
- Contention: req_u=11 from Idle after reset gives gnt=01. Dropping req_u[0] gives State=2 for 2 cycles, then Idle. The next edge gives gnt=10 and u=10.
- Sensors: door 0 granted with req_u; o[0]=1 gives u=00 in the same cycle and the counter holds. Door 0 with req_d and s[0]=1 gives d=00. With s[0]=0 and c[0]=0, d=01.
- Watchdog:
  - Door 1 holds req_d with c=s=0 for 8 driven cycles, giving fault=10, gnt=00, State=2.
  - Door 1 requests are then ignored, and door 0 is granted.
  - clr=1 gives fault=00. clr pulsed at the timeout edge leaves fault=10.
- Illegal request: req_u=req_d=01 gives no grant and State stays 0. A simultaneous valid door 1 request is granted.
- Reset mid-Run: r rises between edges and u=00, gnt=00 immediately. After release, door 0 is served first.

Source files
------------

// File: rtl/door_motor_arbiter.sv
// Round-robin arbiter sharing one motor supply between two door controllers,
// with sensor-gated drive, a settle gap between grants and a travel watchdog.
module door_motor_arbiter #(
   parameter int TIMEOUT = 200,
   parameter int SETTLE  = 4
) (
   input  logic       clk,
   input  logic       r,
   input  logic [1:0] req_u,
   input  logic [1:0] req_d,
   input  logic [1:0] c,
   input  logic [1:0] o,
   input  logic [1:0] s,
   input  logic       clr,
   output logic [1:0] u,
   output logic [1:0] d,
   output logic [1:0] gnt,
   output logic [1:0] fault,
   output logic [1:0] State
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned SW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SETL = 2'd2,
      RSVD = 2'd3
   } state_t;

   state_t          st_q, st_n;
   logic [1:0]      gnt_q, gnt_n;
   logic [1:0]      fault_q, fault_n;
   logic            last_q, last_n;
   logic [TW-1:0]   dcnt_q, dcnt_n;
   logic [SW-1:0]   scnt_q, scnt_n;
   logic [1:0]      vreq;
   logic            gi;
   logic            drv;
   logic            win;

   assign vreq = (req_u ^ req_d) & ~fault_q;
   assign gi   = gnt_q[1];

   // gnt is only non-zero in Run, so drive needs no extra state qualification
   assign u   = gnt_q & req_u & ~o;
   assign d   = gnt_q & req_d & ~c & ~s;
   assign drv = |(u | d);

   assign gnt   = gnt_q;
   assign fault = fault_q;
   assign State = st_q;

   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         st_q    <= IDLE;
         gnt_q   <= '0;
         fault_q <= '0;
         last_q  <= 1'b1;
         dcnt_q  <= '0;
         scnt_q  <= '0;
      end else begin
         st_q    <= st_n;
         gnt_q   <= gnt_n;
         fault_q <= fault_n;
         last_q  <= last_n;
         dcnt_q  <= dcnt_n;
         scnt_q  <= scnt_n;
      end
   end

   always_comb begin
      st_n    = st_q;
      gnt_n   = gnt_q;
      last_n  = last_q;
      dcnt_n  = dcnt_q;
      scnt_n  = scnt_q;
      win     = 1'b0;
      // clear is applied first so a same-edge timeout below overrides it
      fault_n = clr ? '0 : fault_q;
      case (st_q)
         IDLE: begin
            if (|vreq) begin
               win    = (vreq == 2'b11) ? ~last_q : vreq[1];
               gnt_n  = win ? 2'b10 : 2'b01;
               last_n = win;
               st_n   = RUN;
               dcnt_n = '0;
               scnt_n = '0;
            end
         end
         RUN: begin
            if (!vreq[gi]) begin
               gnt_n  = '0;
               dcnt_n = '0;
               scnt_n = '0;
               st_n   = SETL;
            end else if (drv) begin
               if (dcnt_q == TW'(TIMEOUT - 1)) begin
                  fault_n[gi] = 1'b1;
                  gnt_n       = '0;
                  dcnt_n      = '0;
                  scnt_n      = '0;
                  st_n        = SETL;
               end else begin
                  dcnt_n = dcnt_q + 1'b1;
               end
            end
         end
         SETL: begin
            gnt_n = '0;
            if (scnt_q == SW'(SETTLE - 1)) begin
               scnt_n = '0;
               dcnt_n = '0;
               st_n   = IDLE;
            end else begin
               scnt_n = scnt_q + 1'b1;
            end
         end
         default: begin
            st_n   = IDLE;
            gnt_n  = '0;
            dcnt_n = '0;
            scnt_n = '0;
         end
      endcase
   end

endmodule
